oka_mul_seq: RTL

- Parametrised, sequential successor to the fixed-width combinational overlap-free Karatsuba (OKA) GF(2) multipliers in the OKA library.
- Computes the carry-less product of two N-bit polynomials with an even/odd split into three half-size sub-products.
- A single shared H×H sub-multiplier is time-multiplexed over three cycles, followed by overlap-free recombination and an optional reduction modulo a field polynomial.
- Sits between operand registers and the field-arithmetic datapath, with valid/ready handshakes on both sides.

---
 rtl/oka_mul_seq.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/oka_mul_seq.sv
// Sequential overlap-free Karatsuba GF(2) multiplier; one shared HxH carry-less core over three cycles.
// Latency 4 cycles (5 with REDUCE); result and out_valid hold in DONE until out_ready, no input accepted meanwhile.
module oka_mul_seq #(
    parameter int unsigned    N      = 15,
    parameter bit             REDUCE = 1'b0,
    parameter logic [N-1:0]   FPOLY  = N'(15'h0003)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-2:0] y,
    output logic           busy
);
    localparam int unsigned H  = (N + 1) / 2;
    localparam int unsigned AW = 2 * H;
    localparam int unsigned PW = 2 * H - 1;
    localparam int unsigned YW = 2 * N - 1;
    localparam int unsigned RW = 4 * H - 1;
    localparam logic [YW-1:0] FEXT = YW'(FPOLY);

    typedef enum logic [2:0] {IDLE, MUL0, MUL1, MUL2, COMB, RED, DONE} state_t;

    state_t        state_q;
    logic [H-1:0]  a0_q, a1_q, b0_q, b1_q;
    logic [H-1:0]  a0_d, a1_d, b0_d, b1_d;
    logic [PW-1:0] p0_q, p1_q, p2_q;
    logic [YW-1:0] acc_q, y_q;
    logic          in_ready_q, out_valid_q, busy_q;

    logic [AW-1:0] ap_d, bp_d;
    logic [H-1:0]  mx_d, my_d;
    logic [PW-1:0] pm_d, m_d;
    logic [RW:0]   wide_d;
    logic [YW-1:0] prod_d, red_d;
    logic          trunc_unused;

    // Even/odd split; operands are zero-padded so odd N leaves the top odd bit 0.
    always_comb begin
        ap_d = AW'(a);
        bp_d = AW'(b);
        a0_d = '0;
        a1_d = '0;
        b0_d = '0;
        b1_d = '0;
        for (int i = 0; i < int'(H); i++) begin
            a0_d[i] = ap_d[2*i];
            a1_d[i] = ap_d[2*i+1];
            b0_d[i] = bp_d[2*i];
            b1_d[i] = bp_d[2*i+1];
        end
    end

    always_comb begin
        mx_d = a0_q;
        my_d = b0_q;
        if (state_q == MUL1) begin
            mx_d = a1_q;
            my_d = b1_q;
        end else if (state_q == MUL2) begin
            mx_d = a0_q ^ a1_q;
            my_d = b0_q ^ b1_q;
        end
        pm_d = '0;
        for (int i = 0; i < int'(H); i++) begin
            if (my_d[i]) pm_d = pm_d ^ (PW'(mx_d) << i);
        end
    end

    // Odd result bits come only from M and even bits only from P0/P1: no overlap, no carries.
    always_comb begin
        m_d    = p0_q ^ p1_q ^ p2_q;
        wide_d = '0;
        for (int i = 0; i < int'(PW); i++) begin
            wide_d[2*i]   = wide_d[2*i] ^ p0_q[i];
            wide_d[2*i+1] = m_d[i];
            wide_d[2*i+2] = wide_d[2*i+2] ^ p1_q[i];
        end
        prod_d = wide_d[YW-1:0];
    end

    assign trunc_unused = ^wide_d[RW:YW];

    always_comb begin
        red_d = acc_q;
        for (int k = int'(YW) - 1; k >= int'(N); k--) begin
            if (red_d[k]) begin
                red_d    = red_d ^ (FEXT << (k - int'(N)));
                red_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a0_q        <= '0;
            a1_q        <= '0;
            b0_q        <= '0;
            b1_q        <= '0;
            p0_q        <= '0;
            p1_q        <= '0;
            p2_q        <= '0;
            acc_q       <= '0;
            y_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a0_q       <= a0_d;
                        a1_q       <= a1_d;
                        b0_q       <= b0_d;
                        b1_q       <= b1_d;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= MUL0;
                    end
                end
                MUL0: begin
                    p0_q    <= pm_d;
                    state_q <= MUL1;
                end
                MUL1: begin
                    p1_q    <= pm_d;
                    state_q <= MUL2;
                end
                MUL2: begin
                    p2_q    <= pm_d;
                    state_q <= COMB;
                end
                COMB: begin
                    if (REDUCE) begin
                        acc_q   <= prod_d;
                        state_q <= RED;
                    end else begin
                        y_q         <= prod_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                RED: begin
                    y_q         <= red_d;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        y_q         <= '0;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign y         = y_q;
endmodule
